tjmono_hit_assembler: RTL

Downstream consumer of the TJ-Monopix data-RX word FIFO. Pops 32-bit tagged fragments (FWFT FIFO, BUS_CLK domain) and checks the identifier and fragment order. Rebuilds each 4-fragment hit into one 112-bit record, decodes it into fields and presents it on a valid/ready stream to the hit histogrammer / event builder. Counts assembled hits, sequence errors and foreign-identifier words.

---
 rtl/tjmono_hit_assembler.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/tjmono_hit_assembler.sv
// TJ-Monopix hit assembler.
// Reads 32-bit tagged fragments from a first-word-fall-through FIFO, checks the
// identifier and fragment order, rebuilds 4-fragment 112-bit hit records and
// presents them on a valid/ready stream through a 1-deep output register.
// Optional feature macro: TJMONO_TOT_CALC_EN. When it is defined, HIT_TOT = TE - LE
// (mod 64) is registered with the record. When it is undefined, HIT_TOT is tied to 0.
module tjmono_hit_assembler #(
  parameter logic [1:0]  IDENTIFIER = 2'b00,
  parameter int unsigned ERR_CNT_W  = 8
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST_N,
  input  logic                 ENABLE,
  input  logic                 FIFO_EMPTY,
  input  logic [31:0]          FIFO_DATA,
  output logic                 FIFO_READ,
  output logic                 HIT_VALID,
  input  logic                 HIT_READY,
  output logic [5:0]           HIT_COL,
  output logic [8:0]           HIT_ROW,
  output logic [5:0]           HIT_TE,
  output logic [5:0]           HIT_LE,
  output logic                 HIT_NOISE,
  output logic [51:0]          HIT_TS,
  output logic [31:0]          HIT_TOKEN_CNT,
  output logic [5:0]           HIT_TOT,
  output logic [31:0]          HIT_CNT,
  output logic [ERR_CNT_W-1:0] SEQ_ERR_CNT,
  output logic [ERR_CNT_W-1:0] ID_ERR_CNT
);

  // Each state's encoding equals the fragment tag it expects next.
  typedef enum logic [1:0] {StExp0 = 2'd0, StExp1 = 2'd1, StExp2 = 2'd2, StExp3 = 2'd3} state_e;

  state_e                 state_q, state_d;
  logic [83:0]            part_q, part_d;
  logic [111:0]           rec_q;
  logic                   valid_q;
  logic [31:0]            hit_cnt_q;
  logic [ERR_CNT_W-1:0]   seq_err_q, id_err_q;

  logic [1:0]   word_id, word_tag, exp_tag;
  logic [27:0]  payload;
  logic         id_ok, is_last, pop, complete, seq_inc, id_inc;
  logic [111:0] rec_new;

  assign word_id  = FIFO_DATA[31:30];
  assign word_tag = FIFO_DATA[29:28];
  assign payload  = FIFO_DATA[27:0];
  assign exp_tag  = state_q;
  assign id_ok    = (word_id == IDENTIFIER);
  assign is_last  = (state_q == StExp3) && (word_tag == 2'b11) && id_ok;
  // Only the completing fragment waits for room in the output register.
  assign pop      = ENABLE && !FIFO_EMPTY && !(is_last && valid_q && !HIT_READY);
  assign complete = pop && is_last;
  assign rec_new  = {payload, part_q};
  assign FIFO_READ = pop;

  // Fragment order checking and partial record assembly.
  always_comb begin
    state_d = state_q;
    part_d  = part_q;
    seq_inc = 1'b0;
    id_inc  = 1'b0;
    if (pop) begin
      if (!id_ok) begin
        id_inc = 1'b1;
      end else if (word_tag == exp_tag) begin
        unique case (word_tag)
          2'b00: begin part_d[27:0]  = payload; state_d = StExp1; end
          2'b01: begin part_d[55:28] = payload; state_d = StExp2; end
          2'b10: begin part_d[83:56] = payload; state_d = StExp3; end
          2'b11: begin part_d        = '0;      state_d = StExp0; end
        endcase
      end else begin
        seq_inc = 1'b1;
        part_d  = '0;
        if (word_tag == 2'b00) begin
          part_d[27:0] = payload;
          state_d      = StExp1;
        end else begin
          state_d = StExp0;
        end
      end
    end
  end

  // State, partial record and saturating error counters.
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      state_q   <= StExp0;
      part_q    <= '0;
      seq_err_q <= '0;
      id_err_q  <= '0;
    end else begin
      state_q <= state_d;
      part_q  <= part_d;
      if (seq_inc && (seq_err_q != '1)) seq_err_q <= seq_err_q + 1'b1;
      if (id_inc && (id_err_q != '1))   id_err_q  <= id_err_q + 1'b1;
    end
  end

  // 1-deep output register; pop gating guarantees room whenever a record completes.
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      rec_q     <= '0;
      valid_q   <= 1'b0;
      hit_cnt_q <= '0;
    end else begin
      if (complete) begin
        rec_q     <= rec_new;
        valid_q   <= 1'b1;
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end else if (HIT_READY) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef TJMONO_TOT_CALC_EN
  logic [5:0] tot_q;

  // Time over threshold, registered alongside the record.
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      tot_q <= '0;
    end else if (complete) begin
      tot_q <= rec_new[20:15] - rec_new[26:21];
    end
  end

  assign HIT_TOT = tot_q;
`else
  assign HIT_TOT = '0;
`endif

  assign HIT_VALID     = valid_q;
  assign HIT_COL       = rec_q[5:0];
  assign HIT_ROW       = rec_q[14:6];
  assign HIT_TE        = rec_q[20:15];
  assign HIT_LE        = rec_q[26:21];
  assign HIT_NOISE     = rec_q[27];
  assign HIT_TS        = rec_q[79:28];
  assign HIT_TOKEN_CNT = rec_q[111:80];
  assign HIT_CNT       = hit_cnt_q;
  assign SEQ_ERR_CNT   = seq_err_q;
  assign ID_ERR_CNT    = id_err_q;

endmodule
